// File: rtl/irrigation_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : irrigation_pkg
// Brief   : FSM state type and default width constants shared by the
//           irrigation blocks.
// Revision: 1.0 - initial release
// ============================================================================
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    COOL = 2'd3
  } irr_state_t;

  localparam int DEF_N_REQ          = 2;
  localparam int DEF_DUR_W          = 8;
  localparam int DEF_COOLDOWN_TICKS = 2;

endpackage
`default_nettype wire

// File: rtl/irrigation_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : irrigation_timer_ctrl_if
// Brief   : Valve request / grant bundle between requesters (master) and the
//           pump timer controller (slave).
//           IRRIGATION_TIMER_ABORT_EN adds the abort input.
// Revision: 1.0 - initial release
// ============================================================================
interface irrigation_timer_ctrl_if
  import irrigation_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DUR_W = DEF_DUR_W
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*DUR_W-1:0] duration;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [DUR_W-1:0]       remaining;

`ifdef IRRIGATION_TIMER_ABORT_EN
  logic                   abort;

  modport master (output req, duration, abort,
                  input  grant, done, busy, remaining);
  modport slave  (input  req, duration, abort,
                  output grant, done, busy, remaining);
`else
  modport master (output req, duration,
                  input  grant, done, busy, remaining);
  modport slave  (input  req, duration,
                  output grant, done, busy, remaining);
`endif

endinterface
`default_nettype wire

// File: rtl/irrigation_timer_ctrl_tick_sync.sv
`default_nettype none
// ============================================================================
// Module  : tick_sync
// Brief   : Two-flop synchronizer for the divided tick plus rising-edge
//           detect; tick_edge is one clock wide per tick_in rise.
// Revision: 1.0 - initial release
// ============================================================================
module tick_sync (
  input  logic clock,
  input  logic reset,
  input  logic tick_in,
  output logic tick_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync_d;

  // Synchronize the foreign-domain tick and keep one delayed copy for edge detect
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= tick_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign tick_edge = r_sync2 & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/irrigation_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : irrigation_timer_ctrl
// Brief   : Round-robin pump arbiter that opens one valve for a tick-counted
//           session, then enforces a cooldown before the next session.
//           IRRIGATION_TIMER_ABORT_EN adds an abort input that ends RUN early.
// Revision: 1.0 - initial release
// ============================================================================
module irrigation_timer_ctrl
  import irrigation_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int DUR_W          = DEF_DUR_W,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_in,
  irrigation_timer_ctrl_if.slave bus
);

  localparam int         IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] COOL_INIT = 8'(COOLDOWN_TICKS);

  irr_state_t       r_state,  w_state_nxt;
  logic [IDX_W-1:0] r_winner, w_winner_nxt;
  logic [IDX_W-1:0] r_last,   w_last_nxt;
  logic [DUR_W-1:0] r_rem,    w_rem_nxt;
  logic [7:0]       r_cool,   w_cool_nxt;

  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_rr_cand;
  logic             w_rr_hit;
  logic [DUR_W-1:0] w_rr_dur;
  logic             w_tick_edge;
  logic             w_abort;

  tick_sync u_tick_sync (
    .clock     (clock),
    .reset     (reset),
    .tick_in   (tick_in),
    .tick_edge (w_tick_edge)
  );

`ifdef IRRIGATION_TIMER_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Round-robin search: first active request after the last served index
  always_comb begin
    w_rr_hit  = 1'b0;
    w_rr_idx  = r_last;
    w_rr_cand = r_last;
    for (int i = 1; i <= N_REQ; i++) begin
      w_rr_cand = IDX_W'((int'(r_last) + i) % N_REQ);
      if (!w_rr_hit && bus.req[w_rr_cand]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_rr_cand;
      end
    end
  end

  // Duration slice of the candidate winner, only consumed in IDLE
  always_comb begin
    w_rr_dur = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_rr_idx == IDX_W'(k)) w_rr_dur = bus.duration[k*DUR_W +: DUR_W];
    end
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_winner <= '0;
      r_last   <= IDX_W'(N_REQ - 1);
      r_rem    <= '0;
      r_cool   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_winner <= w_winner_nxt;
      r_last   <= w_last_nxt;
      r_rem    <= w_rem_nxt;
      r_cool   <= w_cool_nxt;
    end
  end

  // Next-state logic; ticks only count in RUN and COOL, so a tick landing on
  // the selection cycle is dropped and a released request does not end RUN
  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    w_last_nxt   = r_last;
    w_rem_nxt    = r_rem;
    w_cool_nxt   = r_cool;
    case (r_state)
      IDLE: begin
        if (w_rr_hit) begin
          w_winner_nxt = w_rr_idx;
          w_rem_nxt    = w_rr_dur;
          w_state_nxt  = (w_rr_dur == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_abort) begin
          w_rem_nxt   = '0;
          w_state_nxt = DONE;
        end else if (w_tick_edge) begin
          if (r_rem == DUR_W'(1)) begin
            w_rem_nxt   = '0;
            w_state_nxt = DONE;
          end else begin
            w_rem_nxt = r_rem - DUR_W'(1);
          end
        end
      end
      DONE: begin
        w_last_nxt  = r_winner;
        w_cool_nxt  = COOL_INIT;
        w_state_nxt = COOL;
      end
      COOL: begin
        if (w_tick_edge) begin
          if (r_cool <= 8'd1) begin
            w_cool_nxt  = 8'd0;
            w_state_nxt = IDLE;
          end else begin
            w_cool_nxt = r_cool - 8'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Valve and done decode from state and winner; at most one bit by construction
  always_comb begin
    bus.grant = '0;
    bus.done  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_winner == IDX_W'(k)) begin
        bus.grant[k] = (r_state == RUN);
        bus.done[k]  = (r_state == DONE);
      end
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.remaining = (r_state == RUN) ? r_rem : '0;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_irrigation_timer_ctrl
// Brief   : Directed, table-driven bench for irrigation_timer_ctrl.
//           IRRIGATION_TIMER_ABORT_EN enables the abort sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_irrigation_timer_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tick_in = 1'b0;

  irrigation_timer_ctrl_if #(.N_REQ(2), .DUR_W(8)) bus ();

  irrigation_timer_ctrl #(.N_REQ(2), .DUR_W(8), .COOLDOWN_TICKS(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .tick_in (tick_in),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int done0_cnt = 0;
  int done1_cnt = 0;
  int multi_cnt = 0;
  int gstart_n  = 0;
  logic [1:0] gstart [16];
  logic [1:0] prev_grant = 2'b00;

  // Observe outputs mid-cycle: count done pulses, multi-grant cycles, grant starts
  always @(negedge clock) begin
    if (bus.done[0]) done0_cnt <= done0_cnt + 1;
    if (bus.done[1]) done1_cnt <= done1_cnt + 1;
    if ($countones(bus.grant) > 1) multi_cnt <= multi_cnt + 1;
    if (bus.grant != 2'b00 && prev_grant == 2'b00 && gstart_n < 16) begin
      gstart[gstart_n] <= bus.grant;
      gstart_n <= gstart_n + 1;
    end
    prev_grant <= bus.grant;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One tick_in rise; the counted edge lands 3 clocks in, task spans 6 clocks
  task automatic tick();
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
    cyc(5);
  endtask

  task automatic do_reset();
    bus.req = '0;
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_grant;
    logic [7:0] exp_dur;
    int         exp_done_idx;
  } vec_t;

  vec_t vecs [4];

  initial begin : main
    int b0, b1, m0, g0;
    vecs[0] = '{req: 2'b01, d0: 8'd3, d1: 8'd5, exp_grant: 2'b01, exp_dur: 8'd3, exp_done_idx: 0};
    vecs[1] = '{req: 2'b10, d0: 8'd3, d1: 8'd2, exp_grant: 2'b10, exp_dur: 8'd2, exp_done_idx: 1};
    vecs[2] = '{req: 2'b11, d0: 8'd1, d1: 8'd4, exp_grant: 2'b01, exp_dur: 8'd1, exp_done_idx: 0};
    vecs[3] = '{req: 2'b10, d0: 8'd6, d1: 8'd0, exp_grant: 2'b00, exp_dur: 8'd0, exp_done_idx: 1};

    bus.req = '0;
    bus.duration = '0;
`ifdef IRRIGATION_TIMER_ABORT_EN
    bus.abort = 1'b0;
`endif

    // Reset values while reset is held low
    cyc(3);
    check("rst_grant", bus.grant, 2'b00);
    check("rst_done", bus.done, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rem", bus.remaining, 8'd0);
    reset = 1'b1;
    cyc(1);

    // Table-driven single sessions; req is dropped once granted
    for (int v = 0; v < 4; v++) begin
      do_reset();
      b0 = done0_cnt;
      b1 = done1_cnt;
      bus.duration = {vecs[v].d1, vecs[v].d0};
      bus.req = vecs[v].req;
      cyc(2);
      check($sformatf("v%0d_grant_load", v), bus.grant, vecs[v].exp_grant);
      check($sformatf("v%0d_rem_load", v), bus.remaining, vecs[v].exp_dur);
      bus.req = '0;
      bus.duration = '1;
      for (int k = 1; k <= int'(vecs[v].exp_dur); k++) begin
        tick();
        if (k < int'(vecs[v].exp_dur)) begin
          check($sformatf("v%0d_rem_t%0d", v, k), bus.remaining, vecs[v].exp_dur - 8'(k));
          check($sformatf("v%0d_grant_t%0d", v, k), bus.grant, vecs[v].exp_grant);
        end
      end
      @(negedge clock);
      check($sformatf("v%0d_done0", v), done0_cnt - b0, (vecs[v].exp_done_idx == 0) ? 1 : 0);
      check($sformatf("v%0d_done1", v), done1_cnt - b1, (vecs[v].exp_done_idx == 1) ? 1 : 0);
      check($sformatf("v%0d_grant_end", v), bus.grant, 2'b00);
      check($sformatf("v%0d_busy_cool", v), bus.busy, 1'b1);
      tick();
      check($sformatf("v%0d_busy_cool1", v), bus.busy, 1'b1);
      tick();
      check($sformatf("v%0d_busy_idle", v), bus.busy, 1'b0);
    end

    // Both requesters held: grants alternate with cooldown gaps
    do_reset();
    m0 = multi_cnt;
    g0 = gstart_n;
    bus.duration = {8'd2, 8'd2};
    bus.req = 2'b11;
    repeat (16) tick();
    bus.req = '0;
    @(negedge clock);
    check("alt_count", (gstart_n - g0) >= 3, 1);
    check("alt_first", gstart[g0], 2'b01);
    check("alt_second", gstart[g0 + 1], 2'b10);
    check("alt_third", gstart[g0 + 2], 2'b01);
    check("alt_multi", multi_cnt - m0, 0);

    // Reset mid-RUN drops grant on the reset edge with no done pulse
    do_reset();
    bus.duration = {8'd0, 8'd7};
    bus.req = 2'b01;
    cyc(2);
    tick();
    tick();
    check("rmid_rem5", bus.remaining, 8'd5);
    bus.req = '0;
    b0 = done0_cnt;
    reset = 1'b0;
    cyc(1);
    check("rmid_grant", bus.grant, 2'b00);
    check("rmid_rem", bus.remaining, 8'd0);
    check("rmid_busy", bus.busy, 1'b0);
    @(negedge clock);
    check("rmid_done", done0_cnt - b0, 0);
    reset = 1'b1;
    cyc(1);

    // Tick edge coincident with the selection cycle is not counted
    do_reset();
    bus.duration = {8'd0, 8'd1};
    b0 = done0_cnt;
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
    cyc(1);
    bus.req = 2'b01;
    cyc(1);
    bus.req = '0;
    check("coin_grant", bus.grant, 2'b01);
    check("coin_rem", bus.remaining, 8'd1);
    cyc(3);
    check("coin_still", bus.grant, 2'b01);
    tick();
    check("coin_done", done0_cnt - b0, 1);
    check("coin_end", bus.grant, 2'b00);

`ifdef IRRIGATION_TIMER_ABORT_EN
    // Abort in RUN ends the session on the next edge, then cools down
    do_reset();
    bus.duration = {8'd0, 8'd6};
    bus.req = 2'b01;
    cyc(2);
    bus.req = '0;
    tick();
    tick();
    check("ab_rem4", bus.remaining, 8'd4);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    check("ab_grant", bus.grant, 2'b00);
    check("ab_done", bus.done, 2'b01);
    cyc(1);
    check("ab_cool_busy", bus.busy, 1'b1);
    check("ab_cool_done", bus.done, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
